// File: rtl/sprite_pixel_fetch.sv
// Sprite/map pixel fetch: per-pixel map and character RAM addressing,
// 1-cycle RAM latency absorption, sprite transparency compositing.
module sprite_pixel_fetch #(
  parameter int unsigned MAP_W    = 320,
  parameter int unsigned SPR_W    = 16,
  parameter int unsigned ANIM_DIV = 8,
  parameter logic [7:0]  TRANSP   = 8'h00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pixel_valid,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        frame_start,
  input  logic [9:0]  char_x,
  input  logic [9:0]  char_y,
  input  logic [1:0]  char_dir,
  input  logic        char_moving,
  output logic [18:0] map_read_address,
  input  logic [7:0]  map_data,
  output logic [12:0] char_read_address,
  input  logic [7:0]  char_data,
  output logic [7:0]  pixel_index,
  output logic        pixel_out_valid
);

  localparam int unsigned CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  // Per-frame latched sprite state
  logic [9:0]       char_x_l;
  logic [9:0]       char_y_l;
  logic [1:0]       char_dir_l;
  logic [CNT_W-1:0] anim_cnt;
  logic [1:0]       anim_step;

  // Stage A / B pipeline flags
  logic a_valid, a_on, a_hit;
  logic b_valid, b_on, b_hit;

  // Address-stage combinational values
  logic        on_scr;
  logic [10:0] dx, dy;
  logic        hit;
  logic [3:0]  frame_c;
  logic [18:0] map_addr_c;
  logic [12:0] char_addr_c;
  logic [7:0]  pix_c;

  // Sample sprite position/facing once per frame and advance the walk cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      char_x_l   <= '0;
      char_y_l   <= '0;
      char_dir_l <= '0;
      anim_cnt   <= '0;
      anim_step  <= '0;
    end else if (frame_start) begin
      char_x_l   <= char_x;
      char_y_l   <= char_y;
      char_dir_l <= char_dir;
      if (char_moving) begin
        if (anim_cnt == CNT_W'(ANIM_DIV - 1)) begin
          anim_cnt  <= '0;
          anim_step <= (anim_step == 2'd2) ? 2'd0 : anim_step + 2'd1;
        end else begin
          anim_cnt <= anim_cnt + 1'b1;
        end
      end else begin
        anim_cnt  <= '0;
        anim_step <= '0;
      end
    end
  end

  // Screen bounds, sprite hit test and RAM address generation
  always_comb begin
    on_scr  = (DrawX < 10'd640) && (DrawY < 10'd480);
    dx      = {1'b0, DrawX} - {1'b0, char_x_l};
    dy      = {1'b0, DrawY} - {1'b0, char_y_l};
    // Explicit >= checks rule out wraparound: an underflowed dx/dy never hits
    hit     = on_scr && (DrawX >= char_x_l) && (DrawY >= char_y_l) &&
              (dx < 11'(2 * SPR_W)) && (dy < 11'(2 * SPR_W));
    frame_c = {2'b00, char_dir_l} * 4'd3 + {2'b00, anim_step};
    map_addr_c = '0;
    if (on_scr)
      map_addr_c = 19'(32'(DrawY[9:1]) * MAP_W + 32'(DrawX[9:1]));
    char_addr_c = '0;
    if (hit)
      char_addr_c = 13'(32'(frame_c) * SPR_W * SPR_W +
                        32'(dy[10:1]) * SPR_W + 32'(dx[10:1]));
  end

  // Stage A: register RAM addresses and per-pixel flags
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      map_read_address  <= '0;
      char_read_address <= '0;
      a_valid           <= 1'b0;
      a_on              <= 1'b0;
      a_hit             <= 1'b0;
    end else begin
      map_read_address  <= map_addr_c;
      char_read_address <= char_addr_c;
      a_valid           <= pixel_valid;
      a_on              <= on_scr;
      a_hit             <= hit;
    end
  end

  // Stage B: carry flags alongside the RAM read latency
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      b_valid <= 1'b0;
      b_on    <= 1'b0;
      b_hit   <= 1'b0;
    end else begin
      b_valid <= a_valid;
      b_on    <= a_on;
      b_hit   <= a_hit;
    end
  end

  // Composite: opaque sprite pixel over map, black off-screen
  always_comb begin
    pix_c = map_data;
    if (!b_on)
      pix_c = '0;
    else if (b_hit && (char_data != TRANSP))
      pix_c = char_data;
  end

  // Output stage
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pixel_index     <= '0;
      pixel_out_valid <= 1'b0;
    end else begin
      pixel_index     <= b_valid ? pix_c : '0;
      pixel_out_valid <= b_valid;
    end
  end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Self-checking bench for sprite_pixel_fetch with behavioural RAM and pixel model.
module tb_sprite_pixel_fetch;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pixel_valid = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        frame_start = 1'b0;
  logic [9:0]  char_x = '0, char_y = '0;
  logic [1:0]  char_dir = '0;
  logic        char_moving = 1'b0;
  logic [18:0] map_read_address;
  logic [7:0]  map_data = '0;
  logic [12:0] char_read_address;
  logic [7:0]  char_data = '0;
  logic [7:0]  pixel_index;
  logic        pixel_out_valid;

  sprite_pixel_fetch #(.MAP_W(320), .SPR_W(16), .ANIM_DIV(8), .TRANSP(8'h00)) dut (
    .Clk(Clk), .Reset(Reset), .pixel_valid(pixel_valid), .DrawX(DrawX), .DrawY(DrawY),
    .frame_start(frame_start), .char_x(char_x), .char_y(char_y), .char_dir(char_dir),
    .char_moving(char_moving), .map_read_address(map_read_address), .map_data(map_data),
    .char_read_address(char_read_address), .char_data(char_data),
    .pixel_index(pixel_index), .pixel_out_valid(pixel_out_valid)
  );

  always #5 Clk = ~Clk;

  // Registered-output RAM models
  logic [7:0] map_mem  [0:76799];
  logic [7:0] char_mem [0:3071];
  always @(posedge Clk) begin
    map_data  <= (map_read_address < 19'd76800) ? map_mem[map_read_address] : 8'hEE;
    char_data <= (char_read_address < 13'd3072) ? char_mem[char_read_address] : 8'hEE;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model state
  int m_cx = 0, m_cy = 0, m_dir = 0, m_n = 0;
  typedef struct { bit v; int map; int chr; int idx; } exp_t;
  exp_t hist [3];
  int last_idx = -1;

  function automatic exp_t model_pix(input bit pv, input int x, input int y);
    exp_t e;
    bit on, h;
    int step;
    e.v = pv;
    on  = (x < 640) && (y < 480);
    h   = on && (x >= m_cx) && (y >= m_cy) && (x - m_cx < 32) && (y - m_cy < 32);
    step = (m_n / 8) % 3;
    e.map = on ? (y / 2) * 320 + x / 2 : 0;
    e.chr = h ? (m_dir * 3 + step) * 256 + ((y - m_cy) / 2) * 16 + (x - m_cx) / 2 : 0;
    if (!on)                          e.idx = 0;
    else if (h && char_mem[e.chr] != 0) e.idx = int'(char_mem[e.chr]);
    else                              e.idx = int'(map_mem[e.map]);
    return e;
  endfunction

  task automatic set_char(input int cx, input int cy, input int dir, input bit mv);
    char_x = 10'(cx); char_y = 10'(cy); char_dir = 2'(dir); char_moving = mv;
  endtask

  // One clock: drive a pixel (and optional frame_start), check addresses and output
  task automatic step(input bit pv, input int x, input int y, input bit fs);
    exp_t cur;
    pixel_valid = pv; DrawX = 10'(x); DrawY = 10'(y); frame_start = fs;
    cur = model_pix(pv, x, y);
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = cur;
    @(posedge Clk); #1;
    if (pv) begin
      chk("map_addr", int'(map_read_address), cur.map);
      chk("char_addr", int'(char_read_address), cur.chr);
    end
    chk("out_valid", int'(pixel_out_valid), int'(hist[2].v));
    if (hist[2].v) begin
      chk("pixel_index", int'(pixel_index), hist[2].idx);
      last_idx = int'(pixel_index);
    end
    if (fs) begin
      m_cx = int'(char_x); m_cy = int'(char_y); m_dir = int'(char_dir);
      m_n  = char_moving ? m_n + 1 : 0;
    end
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    #2 Reset = 1'b1;
    #1;
    chk("rst_map_addr", int'(map_read_address), 0);
    chk("rst_char_addr", int'(char_read_address), 0);
    chk("rst_index", int'(pixel_index), 0);
    chk("rst_valid", int'(pixel_out_valid), 0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    m_cx = 0; m_cy = 0; m_dir = 0; m_n = 0;
    for (int i = 0; i < 3; i++) hist[i].v = 1'b0;
  endtask

  typedef struct {
    int cx; int cy; int dir; int x; int y; int exp_map; int exp_chr;
  } vec_t;
  vec_t tbl [10];

  initial begin
    // Directed address vectors, expected values worked by hand
    tbl[0] = '{0,   0,   0, 5,   3,   322,   18};
    tbl[1] = '{100, 50,  3, 101, 51,  8050,  2304};
    tbl[2] = '{630, 0,   2, 639, 10,  1919,  1620};
    tbl[3] = '{630, 0,   2, 0,   10,  1600,  0};
    tbl[4] = '{0,   0,   0, 700, 10,  0,     0};
    tbl[5] = '{200, 100, 1, 231, 131, 20915, 1023};
    tbl[6] = '{200, 100, 1, 232, 131, 20916, 0};
    tbl[7] = '{200, 100, 1, 199, 100, 16099, 0};
    tbl[8] = '{620, 460, 3, 639, 479, 76799, 2457};
    tbl[9] = '{630, 0,   0, 640, 0,   0,     0};

    for (int i = 0; i < 76800; i++) map_mem[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < 3072; i++)
      char_mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    for (int i = 0; i < 3; i++) hist[i] = '{1'b0, 0, 0, 0};

    @(posedge Clk); #1;
    do_reset();

    // Pixel right after reset at position 0/0 with a transparent sprite texel
    char_mem[18] = 8'h00;
    step(1'b1, 5, 3, 1'b0);
    chk("t1_map_addr", int'(map_read_address), 322);
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    chk("t1_index_is_map", last_idx, int'(map_mem[322]));

    // Table-driven address vectors
    for (int i = 0; i < 10; i++) begin
      set_char(tbl[i].cx, tbl[i].cy, tbl[i].dir, 1'b0);
      step(1'b0, 0, 0, 1'b1);
      step(1'b1, tbl[i].x, tbl[i].y, 1'b0);
      chk($sformatf("tbl%0d_map", i), int'(map_read_address), tbl[i].exp_map);
      chk($sformatf("tbl%0d_char", i), int'(char_read_address), tbl[i].exp_chr);
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);
    end

    // Opaque vs transparent sprite texel
    set_char(100, 50, 3, 1'b0);
    step(1'b0, 0, 0, 1'b1);
    char_mem[2304] = 8'h2A;
    step(1'b1, 101, 51, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    chk("t2_opaque", last_idx, 8'h2A);
    char_mem[2304] = 8'h00;
    step(1'b1, 101, 51, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    chk("t2_transparent", last_idx, int'(map_mem[8050]));

    // Walk animation: 24 moving pulses, then stop
    for (int p = 1; p <= 24; p++) begin
      set_char(0, 0, 0, 1'b1);
      step(1'b0, 0, 0, 1'b1);
      step(1'b1, 0, 0, 1'b0);
      if (p == 7)  chk("anim_p7",  int'(char_read_address), 0);
      if (p == 8)  chk("anim_p8",  int'(char_read_address), 256);
      if (p == 16) chk("anim_p16", int'(char_read_address), 512);
      if (p == 24) chk("anim_p24", int'(char_read_address), 0);
    end
    for (int p = 0; p < 9; p++) begin
      step(1'b0, 0, 0, 1'b1);
    end
    step(1'b1, 0, 0, 1'b0);
    chk("anim_p33", int'(char_read_address), 256);
    set_char(0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1);
    step(1'b1, 0, 0, 1'b0);
    chk("anim_stop", int'(char_read_address), 0);

    // frame_start coincident with a valid pixel: that pixel sees the old position
    set_char(300, 300, 1, 1'b0);
    step(1'b1, 0, 0, 1'b1);
    chk("coincident_old", int'(char_read_address), 0);
    step(1'b1, 300, 300, 1'b0);
    chk("coincident_new", int'(char_read_address), 768);

    // Continuous stream with reset mid-line
    for (int i = 0; i < 12; i++) step(1'b1, 100 + i, 200, 1'b0);
    do_reset();
    step(1'b1, 700, 200, 1'b0);
    chk("t5_offscreen_map", int'(map_read_address), 0);
    for (int i = 0; i < 8; i++) step(1'b1, 600 + 10 * i, 470 + i, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit fs, pv;
      int x, y;
      fs = ($urandom_range(0, 19) == 0);
      pv = ($urandom_range(0, 4) != 0);
      if (fs) set_char(int'($urandom_range(0, 660)), int'($urandom_range(0, 500)),
                       int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 1) == 0) begin
        x = m_cx + int'($urandom_range(0, 40)) - 4;
        y = m_cy + int'($urandom_range(0, 40)) - 4;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        if (x > 1023) x = 1023;
        if (y > 1023) y = 1023;
      end else begin
        x = int'($urandom_range(0, 719));
        y = int'($urandom_range(0, 524));
      end
      step(pv, x, y, fs);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
